// File: rtl/alu_op_sequencer_pkg.sv
// +--------------------------------------------------------------------+
// | alu_seq_pkg: opcodes, sequencer states and opcode classifiers      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_seq_pkg;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd3;
  localparam logic [4:0] OP_SUB = 5'd4;
  localparam logic [4:0] OP_MUL = 5'd15;
  localparam logic [4:0] OP_DIV = 5'd16;
  localparam logic [4:0] OP_NOT = 5'd18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_Y = 2'd1,
    EXEC   = 2'd2,
    RESP   = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [4:0] opc);
    return (opc >= OP_ADD) && (opc <= OP_NOT);
  endfunction

  function automatic logic is_wide(input logic [4:0] opc);
    return (opc == OP_MUL) || (opc == OP_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
// +--------------------------------------------------------------------+
// | alu_op_sequencer_if: request/response channels of the sequencer    |
// | Optional macro: ALU_SEQ_DIV0_CHECK_EN adds rsp_div0. Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

interface alu_op_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [OPC_W-1:0]  req_opcode;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_lo;
  logic [DATA_W-1:0] rsp_hi;
  logic              rsp_wide;
  logic              rsp_illegal;
`ifdef ALU_SEQ_DIV0_CHECK_EN
  logic              rsp_div0;
`endif

  modport master (
    output req_valid, req_opcode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_wide, rsp_illegal
`ifdef ALU_SEQ_DIV0_CHECK_EN
    , input rsp_div0
`endif
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_wide, rsp_illegal
`ifdef ALU_SEQ_DIV0_CHECK_EN
    , output rsp_div0
`endif
  );
endinterface

`default_nettype wire

// File: rtl/alu_op_sequencer_decode.sv
// +--------------------------------------------------------------------+
// | alu_seq_decode: combinational opcode classifier (legal / wide)     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opc,
  output logic             legal,
  output logic             wide
);
  assign legal = is_legal(opc);
  assign wide  = is_wide(opc);
endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// +--------------------------------------------------------------------+
// | alu_op_sequencer: multi-cycle controller for the shared wide ALU   |
// | Optional macro: ALU_SEQ_DIV0_CHECK_EN (div-by-zero short cut). 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int OPC_W       = 5,
  parameter int MULDIV_WAIT = 2
) (
  input  logic                clk,
  input  logic                reset,
  alu_op_sequencer_if.slave   bus,
  output logic [OPC_W-1:0]    alu_instruction,
  output logic [DATA_W-1:0]   alu_y,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                busy
);
  localparam logic [3:0] WAIT_LD = 4'(MULDIV_WAIT);

  state_t              state, state_nxt;
  logic [OPC_W-1:0]    opc_q;
  logic [DATA_W-1:0]   a_q, b_q, y_q;
  logic [3:0]          cnt_q;
  logic [2*DATA_W-1:0] z_q;
  logic                wide_op_q, wide_q, illegal_q;
  logic                dec_legal, dec_wide, accept, rsp_done, div0_hit;

  alu_seq_decode #(.OPC_W(OPC_W)) u_decode (
    .opc   (bus.req_opcode),
    .legal (dec_legal),
    .wide  (dec_wide)
  );

  assign accept   = bus.req_valid && (state == IDLE);
  assign rsp_done = bus.rsp_ready && (state == RESP);

`ifdef ALU_SEQ_DIV0_CHECK_EN
  logic div0_q;
  assign div0_hit     = (bus.req_opcode == OP_DIV) && (bus.req_b == '0);
  assign bus.rsp_div0 = div0_q;

  always_ff @(posedge clk) begin
    if (reset)                  div0_q <= 1'b0;
    else if (accept && div0_hit) div0_q <= 1'b1;
    else if (rsp_done)          div0_q <= 1'b0;
  end
`else
  assign div0_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (!dec_legal || div0_hit) ? RESP : LOAD_Y;
      LOAD_Y:  state_nxt = EXEC;
      EXEC:    if (cnt_q == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = (state == IDLE);
    bus.rsp_valid   = (state == RESP);
    busy            = (state != IDLE);
    alu_instruction = (state == EXEC) ? opc_q : '0;
    alu_b           = (state == EXEC) ? b_q : '0;
  end

  // Datapath: operand latch, Y register, wait counter and Z capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      opc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      y_q       <= '0;
      cnt_q     <= 4'd0;
      z_q       <= '0;
      wide_op_q <= 1'b0;
      wide_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          opc_q     <= bus.req_opcode;
          a_q       <= bus.req_a;
          b_q       <= bus.req_b;
          wide_op_q <= dec_wide;
          if (!dec_legal) begin
            illegal_q <= 1'b1;
            z_q       <= '0;
          end else if (div0_hit) begin
            wide_q <= 1'b1;
            z_q    <= '0;
          end
        end
        LOAD_Y: begin
          y_q   <= a_q;
          cnt_q <= wide_op_q ? WAIT_LD : 4'd0;
        end
        EXEC: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            z_q    <= alu_result;
            wide_q <= wide_op_q;
          end
        end
        RESP: if (rsp_done) begin
          wide_q    <= 1'b0;
          illegal_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign alu_y           = y_q;
  assign bus.rsp_lo      = z_q[DATA_W-1:0];
  assign bus.rsp_hi      = z_q[2*DATA_W-1:DATA_W];
  assign bus.rsp_wide    = wide_q;
  assign bus.rsp_illegal = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_alu_op_sequencer: randomized self-checking bench with ALU model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int DW = 32;
  localparam int OW = 5;
  localparam int MW = 2;
`ifdef ALU_SEQ_DIV0_CHECK_EN
  localparam bit DIV0_EN = 1'b1;
`else
  localparam bit DIV0_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_W(DW), .OPC_W(OW)) bus ();
  logic [OW-1:0]   alu_instruction;
  logic [DW-1:0]   alu_y, alu_b;
  logic [2*DW-1:0] alu_result;
  logic            busy;

  alu_op_sequencer #(.DATA_W(DW), .OPC_W(OW), .MULDIV_WAIT(MW)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .alu_instruction (alu_instruction),
    .alu_y           (alu_y),
    .alu_b           (alu_b),
    .alu_result      (alu_result),
    .busy            (busy)
  );

  int tests = 0;
  int fails = 0;

  // Stand-in ALU: instruction 0 yields 0, narrow ops leave the upper half zero.
  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b);
    logic [63:0] r;
    case (op)
      5'd0:  r = 64'd0;
      5'd3:  r = {32'd0, y + b};
      5'd4:  r = {32'd0, y - b};
      5'd15: r = {32'd0, y} * {32'd0, b};
      5'd16: r = (b == 32'd0) ? {y, 32'hFFFF_FFFF} : {y % b, y / b};
      default: r = (op >= 5'd3 && op <= 5'd18) ? {32'd0, y ^ b ^ {27'd0, op}} : 64'd0;
    endcase
    return r;
  endfunction

  assign alu_result = alu_fn(alu_instruction, alu_y, alu_b);

  function automatic void model(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output int execn, output logic [31:0] lo,
                                output logic [31:0] hi, output logic wide, output logic ill,
                                output logic d0);
    logic [63:0] r;
    bit legal = (opc >= 5'd3) && (opc <= 5'd18);
    bit wd    = (opc == 5'd15) || (opc == 5'd16);
    lo = 0; hi = 0; wide = 0; ill = 0; d0 = 0; execn = 0;
    if (!legal) begin
      lat = 1; ill = 1;
    end else if (DIV0_EN && opc == 5'd16 && b == 0) begin
      lat = 1; wide = 1; d0 = 1;
    end else begin
      execn = wd ? MW + 1 : 1;
      lat   = 2 + execn;
      r     = alu_fn(opc, a, b);
      lo = r[31:0]; hi = r[63:32]; wide = wd;
    end
  endfunction

  function automatic logic get_div0();
`ifdef ALU_SEQ_DIV0_CHECK_EN
    return bus.rsp_div0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_op(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output int lat, output int execn, output bit exec_ok,
                        output bit stable, output logic [31:0] lo, output logic [31:0] hi,
                        output logic wide, output logic ill, output logic d0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_opcode = opc; bus.req_a = a; bus.req_b = b;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; execn = 0; exec_ok = 1;
    while (1) begin
      @(negedge clk);
      lat++;
      if (alu_instruction != 0) begin
        execn++;
        if (alu_instruction !== opc || alu_b !== b) exec_ok = 0;
      end else if (alu_b !== 0) exec_ok = 0;
      if (bus.rsp_valid === 1'b1 || lat >= 60) break;
    end
    lo = bus.rsp_lo; hi = bus.rsp_hi; wide = bus.rsp_wide; ill = bus.rsp_illegal; d0 = get_div0();
    stable = 1;
    repeat (hold) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_lo !== lo || bus.rsp_hi !== hi ||
          bus.rsp_wide !== wide || bus.rsp_illegal !== ill || get_div0() !== d0) stable = 0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.rsp_valid, bus.rsp_wide, bus.rsp_illegal, busy, get_div0()} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 00000", {bus.rsp_valid, bus.rsp_wide, bus.rsp_illegal, busy, get_div0()});
    end
    tests++;
    if (alu_instruction !== 0 || alu_y !== 0 || alu_b !== 0) begin
      fails++; $display("FAIL reset_alu: instr=%0d y=%0h b=%0h want 0", alu_instruction, alu_y, alu_b);
    end
    tests++;
    if (bus.rsp_lo !== 0 || bus.rsp_hi !== 0) begin
      fails++; $display("FAIL reset_z: lo=%0h hi=%0h want 0", bus.rsp_lo, bus.rsp_hi);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_directed(input string name, input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
    int lat, execn, elat, eexec; bit eok, stab; logic [31:0] lo, hi, elo, ehi; logic w, il, d, ew, eil, ed;
    model(opc, a, b, elat, eexec, elo, ehi, ew, eil, ed);
    run_op(opc, a, b, 1, lat, execn, eok, stab, lo, hi, w, il, d);
    tests++;
    if (lat !== elat) begin fails++; $display("FAIL %s_latency: got %0d want %0d", name, lat, elat); end
    tests++;
    if (lo !== elo || hi !== ehi) begin
      fails++; $display("FAIL %s_result: got hi=%0h lo=%0h want hi=%0h lo=%0h", name, hi, lo, ehi, elo);
    end
    tests++;
    if ({w, il, d} !== {ew, eil, ed}) begin
      fails++; $display("FAIL %s_flags: got wide/ill/div0=%b want %b", name, {w, il, d}, {ew, eil, ed});
    end
    tests++;
    if (execn !== eexec || !eok) begin
      fails++; $display("FAIL %s_exec: got %0d cycles ok=%0d want %0d ok=1", name, execn, eok, eexec);
    end
  endtask

  task automatic test_backpressure();
    int lat = 0; int bad = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_opcode = OP_SUB; bus.req_a = 32'd10; bus.req_b = 32'd3;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    while (bus.rsp_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL bp_latency: got %0d want 3", lat); end
    bus.req_valid = 1'b1; bus.req_opcode = OP_ADD; bus.req_a = 32'd1; bus.req_b = 32'd2;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_lo !== 32'd7 || bus.req_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL bp_hold: %0d bad cycles want 0 (lo=%0d)", bad, bus.rsp_lo); end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      fails++; $display("FAIL bp_idle: ready=%b busy=%b valid=%b want 1 0 0", bus.req_ready, busy, bus.rsp_valid);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    tests++;
    if (lat !== 3 || bus.rsp_lo !== 32'd3) begin
      fails++; $display("FAIL bp_held_req: lat=%0d lo=%0d want 3 3", lat, bus.rsp_lo);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    int n = 0; int seen = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_opcode = OP_DIV; bus.req_a = 32'd100; bus.req_b = 32'd7;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    while (alu_instruction !== OP_DIV && n < 10) begin @(negedge clk); n++; end
    tests++;
    if (alu_instruction !== OP_DIV) begin fails++; $display("FAIL midop_exec: instr=%0d want 16", alu_instruction); end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1 || {bus.rsp_valid, bus.rsp_wide, bus.rsp_illegal, busy} !== 4'b0 ||
        alu_instruction !== 0 || alu_y !== 0 || alu_b !== 0 || bus.rsp_lo !== 0 || bus.rsp_hi !== 0) begin
      fails++; $display("FAIL midop_reset: ready=%b valid=%b busy=%b instr=%0d y=%0h want reset values",
                        bus.req_ready, bus.rsp_valid, busy, alu_instruction, alu_y);
    end
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (10) begin @(negedge clk); if (bus.rsp_valid === 1'b1) seen++; end
    bus.rsp_ready = 1'b0;
    tests++;
    if (seen != 0) begin fails++; $display("FAIL midop_dropped: rsp_valid seen %0d times want 0", seen); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int lat, execn, elat, eexec, hold; bit eok, stab;
      logic [31:0] a, b, lo, hi, elo, ehi; logic [4:0] opc; logic w, il, d, ew, eil, ed;
      opc  = 5'($urandom_range(0, 31));
      if (i % 5 == 0) opc = ($urandom_range(0, 1) == 1) ? OP_MUL : OP_DIV;
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      hold = $urandom_range(0, 3);
      model(opc, a, b, elat, eexec, elo, ehi, ew, eil, ed);
      run_op(opc, a, b, hold, lat, execn, eok, stab, lo, hi, w, il, d);
      tests++;
      if (lat !== elat || execn !== eexec || !eok || !stab || lo !== elo || hi !== ehi ||
          {w, il, d} !== {ew, eil, ed}) begin
        fails++;
        $display("FAIL rand_%0d op=%0d a=%0h b=%0h: got lat=%0d exec=%0d ok=%0d stab=%0d hi=%0h lo=%0h f=%b want lat=%0d exec=%0d hi=%0h lo=%0h f=%b",
                 i, opc, a, b, lat, execn, eok, stab, hi, lo, {w, il, d}, elat, eexec, ehi, elo, {ew, eil, ed});
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_directed("add", OP_ADD, 32'd5, 32'd7);
    test_directed("mul", OP_MUL, 32'h0001_0000, 32'h0001_0000);
    test_directed("illegal", 5'd0, 32'd1, 32'd1);
    test_directed("illegal_hi", 5'd19, 32'd4, 32'd2);
    test_directed("div", OP_DIV, 32'd100, 32'd7);
    test_directed("div0", OP_DIV, 32'd9, 32'd0);
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle controller that sequences the shared 64-bit-result ALU for one requester at a time.
- Accepts an opcode and two operands over a valid/ready handshake.
- Loads the Y operand register, drives the ALU instruction and B bus, then waits extra cycles for mul/div.
- Captures the 64-bit result into Z lo/hi and returns it over a valid/ready response channel.
- Sits between the control unit (or a future arbiter) and the ALU.

Parameters:
- DATA_W, 32, operand width; result width is 2*DATA_W.
- OPC_W, 5, opcode width.
- MULDIV_WAIT, 2, extra EXEC cycles inserted for mul (5'b01111) and div (5'b10000); legal range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_opcode  in  OPC_W  ALU opcode.
- req_a  in  DATA_W  first operand (goes to Y).
- req_b  in  DATA_W  second operand (B bus).
- alu_instruction  out  OPC_W  to ALU instruction input.
- alu_y  out  DATA_W  registered Y operand to ALU.
- alu_b  out  DATA_W  B operand to ALU.
- alu_result  in  2*DATA_W  ALU combinational result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_lo  out  DATA_W  Z[DATA_W-1:0].
- rsp_hi  out  DATA_W  Z[2*DATA_W-1:DATA_W].
- rsp_wide  out  1  result came from mul/div (hi meaningful).
- rsp_illegal  out  1  opcode outside the legal set.
- busy  out  1  state != IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - req_ready=1 after reset deasserts.
  - rsp_valid, rsp_wide and rsp_illegal are 0; alu_instruction=0; alu_y=0; alu_b=0; rsp_lo=rsp_hi=0; busy=0.
  - A reset mid-operation drops the in-flight request silently.
- Legal opcodes: 5'b00011..5'b10010 inclusive. Wide opcodes: 5'b01111 and 5'b10000.
- States: IDLE, LOAD_Y, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch opcode, A and B.
  - Legal opcode: next state LOAD_Y.
  - Illegal opcode: set rsp_illegal=1, lo=hi=0, next state RESP.
- LOAD_Y:
  - alu_y <= latched A at the end of this cycle.
  - Down-counter loads MULDIV_WAIT if the opcode is wide, else 0.
  - Next state EXEC.
- EXEC:
  - alu_instruction=opcode and alu_b=B for every EXEC cycle.
  - Counter decrements each cycle while nonzero.
  - On the cycle the counter is 0: Z <= alu_result, rsp_wide <= is_wide, next state RESP.
- RESP:
  - rsp_valid=1; lo/hi/flags are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, next state IDLE and flags clear.
- Outside EXEC: alu_instruction=5'b00000, so the ALU produces 0. alu_b=0. alu_y holds its last value.
- Latency, counted from the accept edge to the first rsp_valid cycle:
  - Narrow op: 3 cycles.
  - Wide op: 3+MULDIV_WAIT cycles.
  - Illegal opcode: 1 cycle.
- Throughput: req_ready only in IDLE, so there is at least 1 idle cycle between a response handshake and the next accept. No back-to-back overlap.
- A request with req_valid high while not in IDLE is not accepted and is not lost; the requester holds it.
- Non-wide results: rsp_hi is the ALU-provided upper half, which is zero.

Optional Feature:
- Macro: ALU_SEQ_DIV0_CHECK_EN.
- Defined:
  - div with latched B==0 skips LOAD_Y and EXEC and goes directly to RESP.
  - rsp_lo=rsp_hi=0, rsp_wide=1, and an extra port rsp_div0 (out, 1) is 1.
  - Latency 1 cycle. rsp_div0 is 0 for every other response and on reset.
- Undefined:
  - No rsp_div0 port; divide-by-zero is sequenced normally and the ALU result is returned unmodified.

Decomposition:
- Package alu_seq_pkg holds:
  - Opcode localparams (OP_ADD=5'd3 … OP_NOT=5'd18, OP_MUL, OP_DIV).
  - State enum (IDLE, LOAD_Y, EXEC, RESP).
  - Functions is_legal(opc) and is_wide(opc).
- One sub-module is natural: alu_seq_decode, a combinational opcode classifier producing legal and wide.
- FSM, counter and Z register stay in the top module.

Test Plan:
- add: opc=5'b00011, A=5, B=7, rsp_ready=1 -> rsp_valid 3 cycles after accept, lo=12, hi=0, wide=0, illegal=0. alu_instruction=3 only during the single EXEC cycle.
- mul: opc=5'b01111, A=B=32'h0001_0000, MULDIV_WAIT=2 -> rsp_valid 5 cycles after accept, hi=1, lo=0, wide=1, EXEC lasts 3 cycles.
- Illegal: opc=5'b00000, A=1, B=1 -> rsp_valid next cycle, illegal=1, lo=hi=0, alu_instruction stays 0 throughout.
- Backpressure: sub A=10, B=3, rsp_ready=0 for 5 cycles -> rsp_valid, lo=7 stable, req_ready=0, busy=1, and a second req_valid is not accepted. Raising rsp_ready gives IDLE next cycle.
- Reset mid-op: div A=100, B=7, assert reset during EXEC -> next cycle all outputs reset values, req_ready=1, no rsp_valid ever for that request.
- With ALU_SEQ_DIV0_CHECK_EN: div A=9, B=0 -> rsp_valid 1 cycle after accept, rsp_div0=1, lo=hi=0. Without the macro: rsp_valid 5 cycles after accept, returning whatever the ALU produces.
